// File: rtl/qam_pkg.sv
// Shared 16QAM definitions: symbol width/type and the per-axis Gray map used by
// both the modulator packer and the demodulator de-mapper.
package qam_pkg;

    localparam int QAM_SYM_W = 4;

    typedef logic [QAM_SYM_W-1:0] qam_sym_t;

    // 2-bit binary to Gray: 00->00, 01->01, 10->11, 11->10
    function automatic logic [1:0] gray2(input logic [1:0] b);
        return {b[1], b[1] ^ b[0]};
    endfunction

endpackage

// File: rtl/mod_sym_fifo.sv
// Generic synchronous FIFO with a combinational head read and extra-MSB pointers
// so that full and empty are distinguishable without a separate counter.
module mod_sym_fifo #(
    parameter int W          = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic              serial_clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [W-1:0]      wdata,
    output logic [W-1:0]      rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    logic [ADDR_W:0] wr_ptr_reg;
    logic [ADDR_W:0] rd_ptr_reg;
    logic [W-1:0]    mem [FIFO_DEPTH];
    logic            wr_en;
    logic            rd_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;

    // A write into a full FIFO is fine when the head leaves on the same edge.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge serial_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Entries are cleared on reset so the head output reads 0 out of reset.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
        always_ff @(posedge serial_clk or negedge reset_n) begin
            if (!reset_n)
                mem[gi] <= '0;
            else if (wr_en && (wr_ptr_reg[ADDR_W-1:0] == ADDR_W'(gi)))
                mem[gi] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_reg[ADDR_W-1:0]];

endmodule

// File: rtl/mod_s2p.sv
// Serial-to-parallel 16QAM symbol packer (MSB first) feeding a small symbol FIFO.
// Define MOD_S2P_GRAY_EN to Gray-code each symbol per I/Q half before buffering.
module mod_s2p
    import qam_pkg::*;
#(
    parameter int SYM_W      = QAM_SYM_W,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic              serial_clk,
    input  logic              reset_n,
    input  logic              serial,
    input  logic              serial_valid,
    input  logic              sync,
    output logic [SYM_W-1:0]  signal,
    output logic              signal_valid,
    input  logic              signal_ready,
    output logic              overflow,
    output logic [ADDR_W:0]   fill_level
);

    localparam int CNT_W = $clog2(SYM_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYM_W - 1);

    // Only the first SYM_W-1 bits need storing; the last arrives with the push.
    logic [SYM_W-2:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic             overflow_reg;
    logic             sym_done;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [SYM_W-1:0] sym_raw;
    logic [SYM_W-1:0] sym_wdata;

    // sync always wins over a would-be final bit, so it never completes a symbol.
    assign sym_done = serial_valid && !sync && (bit_cnt_reg == LAST_BIT);
    assign sym_raw  = {shift_reg, serial};
    assign pop      = signal_valid && signal_ready;

    always_ff @(posedge serial_clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (sync) begin
            shift_reg   <= {{(SYM_W-2){1'b0}}, serial & serial_valid};
            bit_cnt_reg <= serial_valid ? CNT_W'(1) : '0;
        end else if (serial_valid) begin
            shift_reg   <= {shift_reg[SYM_W-3:0], serial};
            bit_cnt_reg <= sym_done ? '0 : bit_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge serial_clk or negedge reset_n) begin
        if (!reset_n)
            overflow_reg <= 1'b0;
        else if (sym_done && fifo_full && !pop)
            overflow_reg <= 1'b1;
    end

`ifdef MOD_S2P_GRAY_EN
    assign sym_wdata = {gray2(sym_raw[3:2]), gray2(sym_raw[1:0])};
`else
    assign sym_wdata = sym_raw;
`endif

    mod_sym_fifo #(
        .W          (SYM_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_fifo (
        .serial_clk (serial_clk),
        .reset_n    (reset_n),
        .push       (sym_done),
        .pop        (pop),
        .wdata      (sym_wdata),
        .rdata      (signal),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fill_level)
    );

    assign signal_valid = !fifo_empty;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_mod_s2p.sv
// Self-checking bench for mod_s2p: cycle vector table, hand-written corner
// sequences (overflow, full push+pop, async reset) and a randomized model run.
module tb_mod_s2p;

    logic       serial_clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       serial = 1'b0;
    logic       serial_valid = 1'b0;
    logic       sync = 1'b0;
    logic       signal_ready = 1'b0;
    logic [3:0] signal;
    logic       signal_valid;
    logic       overflow;
    logic [2:0] fill_level;

    int checks = 0;
    int failures = 0;

    mod_s2p dut (
        .serial_clk   (serial_clk),
        .reset_n      (reset_n),
        .serial       (serial),
        .serial_valid (serial_valid),
        .sync         (sync),
        .signal       (signal),
        .signal_valid (signal_valid),
        .signal_ready (signal_ready),
        .overflow     (overflow),
        .fill_level   (fill_level)
    );

    always #5 serial_clk = ~serial_clk;

    typedef struct {
        logic       s, v, sy, r;
        logic       ev;
        logic [3:0] esig;
        logic [2:0] efill;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [3:0] enc(input logic [3:0] s);
`ifdef MOD_S2P_GRAY_EN
        return {s[3], s[3] ^ s[2], s[1], s[1] ^ s[0]};
`else
        return s;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic add(input logic s, v, sy, r, ev, input logic [3:0] esig, input logic [2:0] efill);
        vec_t t;
        t.s = s; t.v = v; t.sy = sy; t.r = r; t.ev = ev; t.esig = esig; t.efill = efill;
        vecs.push_back(t);
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic step(input logic s, v, sy, r);
        serial = s; serial_valid = v; sync = sy; signal_ready = r;
        @(posedge serial_clk);
        #1;
    endtask

    task automatic send_sym(input logic [3:0] sym, input logic r);
        for (int i = 3; i >= 0; i--) step(sym[i], 1'b1, 1'b0, r);
    endtask

    task automatic do_reset();
        serial = 0; serial_valid = 0; sync = 0; signal_ready = 0;
        reset_n = 1'b0;
        #2;
        check("rst_valid", signal_valid, 0);
        check("rst_signal", signal, 0);
        check("rst_fill", fill_level, 0);
        check("rst_overflow", overflow, 0);
        @(posedge serial_clk);
        @(posedge serial_clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] bits;
        logic [3:0] exp_list[4];
        logic       part[$];
        logic [3:0] q[$];
        logic       m_ovf;

        #1;
        do_reset();

        // Vector table: 1011; 1100 with 3-cycle gaps; sync discard; sync without valid
        add(0,0,0,1, 0,4'h0,0);
        add(1,1,0,0, 0,4'h0,0);
        add(0,1,0,0, 0,4'h0,0);
        add(1,1,0,0, 0,4'h0,0);
        add(1,1,0,0, 1,4'hB,1);
        add(0,0,0,1, 0,4'h0,0);
        bits = 4'b1100;
        for (int k = 0; k < 4; k++) begin
            add(bits[3-k],1,0,0, (k == 3), 4'hC, (k == 3) ? 3'd1 : 3'd0);
            if (k < 3)
                for (int g = 0; g < 3; g++) add(~bits[3-k],0,0,0, 0,4'h0,0);
        end
        add(0,0,0,1, 0,4'h0,0);
        add(1,1,0,0, 0,4'h0,0);
        add(0,1,0,0, 0,4'h0,0);
        add(0,1,1,0, 0,4'h0,0);
        add(1,1,0,0, 0,4'h0,0);
        add(1,1,0,0, 0,4'h0,0);
        add(1,1,0,0, 1,4'h7,1);
        add(0,0,0,1, 0,4'h0,0);
        add(1,1,0,0, 0,4'h0,0);
        add(0,1,0,0, 0,4'h0,0);
        add(1,1,0,0, 0,4'h0,0);
        add(1,0,1,0, 0,4'h0,0);
        add(0,1,0,0, 0,4'h0,0);
        add(1,1,0,0, 0,4'h0,0);
        add(0,1,0,0, 0,4'h0,0);
        add(1,1,0,0, 1,4'h5,1);
        add(0,0,0,1, 0,4'h0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].s, vecs[i].v, vecs[i].sy, vecs[i].r);
            check($sformatf("vec%0d_valid", i), signal_valid, vecs[i].ev);
            check($sformatf("vec%0d_fill", i), fill_level, vecs[i].efill);
            if (vecs[i].ev)
                check($sformatf("vec%0d_signal", i), signal, enc(vecs[i].esig));
        end

        // Full FIFO: 4th bit arrives together with a pop
        do_reset();
        for (int k = 10; k < 14; k++) send_sym(4'(k), 1'b0);
        check("full_fill", fill_level, 4);
        step(1,1,0,0); step(0,1,0,0); step(0,1,0,0);
        step(1,1,0,1);
        check("pushpop_fill", fill_level, 4);
        check("pushpop_overflow", overflow, 0);
        exp_list = '{4'd11, 4'd12, 4'd13, 4'd9};
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pushpop_head%0d", k), signal, enc(exp_list[k]));
            step(0,0,0,1);
        end
        check("pushpop_drained", fill_level, 0);

        // Overflow: fifth symbol dropped, flag sticky through drain
        do_reset();
        for (int k = 1; k <= 4; k++) send_sym(4'(k), 1'b0);
        check("ovf_fill4", fill_level, 4);
        check("ovf_before", overflow, 0);
        send_sym(4'd5, 1'b0);
        check("ovf_fill_after", fill_level, 4);
        check("ovf_set", overflow, 1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovf_drain%0d", k), signal, enc(4'(k)));
            step(0,0,0,1);
        end
        check("ovf_drained", fill_level, 0);
        check("ovf_sticky", overflow, 1);

        // Async reset mid-symbol with 2 queued and overflow set
        send_sym(4'd3, 1'b0);
        send_sym(4'd6, 1'b0);
        step(1,1,0,0); step(1,1,0,0);
        check("pre_rst_fill", fill_level, 2);
        do_reset();
        send_sym(4'd1, 1'b0);
        check("post_rst_valid", signal_valid, 1);
        check("post_rst_signal", signal, enc(4'd1));
        check("post_rst_fill", fill_level, 1);

        // Randomized run against a bit-list / symbol-queue model
        do_reset();
        m_ovf = 0;
        for (int c = 0; c < 600; c++) begin
            logic s, v, sy, r, have;
            logic [3:0] sym;
            s  = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 9) < 7);
            sy = ($urandom_range(0, 19) == 0);
            r  = (c < 200) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 6);
            have = 0;
            sym = 0;
            if (sy) begin
                part.delete();
                if (v) part.push_back(s);
            end else if (v) begin
                part.push_back(s);
                if (part.size() == 4) begin
                    sym = {part[0], part[1], part[2], part[3]};
                    have = 1;
                    part.delete();
                end
            end
            if (r && q.size() > 0) void'(q.pop_front());
            if (have) begin
                if (q.size() < 4) q.push_back(enc(sym));
                else m_ovf = 1;
            end
            step(s, v, sy, r);
            check($sformatf("rnd%0d_valid", c), signal_valid, (q.size() > 0));
            check($sformatf("rnd%0d_fill", c), fill_level, q.size());
            check($sformatf("rnd%0d_ovf", c), overflow, m_ovf);
            if (q.size() > 0) check($sformatf("rnd%0d_signal", c), signal, q[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
